// File: rtl/sobel_line_packer.sv
// Packs the 1-bit Sobel pixel stream into MSB-first bytes, one framed packet per line:
// 2-byte line index header, then IMAGE_WIDTH/8 data bytes. No backpressure.
module sobel_line_packer #(
  parameter int IMAGE_WIDTH    = 1280,
  parameter int IMAGE_HEIGHT   = 720,
  parameter int LINE_IDX_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       sobel,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sol,
  output logic       out_eol,
  output logic       out_abort,
  output logic       frame_done,
  output logic       line_err
);

  localparam int PW = $clog2(IMAGE_WIDTH);
  localparam int LW = $clog2(IMAGE_HEIGHT) + 1;

  generate
    if (IMAGE_WIDTH % 8 != 0 || IMAGE_WIDTH < 8) begin : g_bad_width
      $error("sobel_line_packer: IMAGE_WIDTH must be a non-zero multiple of 8");
    end
    if (LINE_IDX_WIDTH < 1 || LINE_IDX_WIDTH > 16) begin : g_bad_idx
      $error("sobel_line_packer: LINE_IDX_WIDTH must be 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_DONE} state_t;

  state_t              state, state_n;
  logic [PW-1:0]       pixel_cnt, pixel_cnt_n;
  logic [LW-1:0]       line_cnt, line_cnt_n;
  logic [6:0]          sr, sr_n;
  logic                vsync_d;
  logic [7:0]          hdr_lo, hdr_lo_n;
  logic                hdr_pend, hdr_pend_n;
  logic [7:0]          out_data_n;
  logic                out_valid_n, out_sol_n, out_eol_n, out_abort_n, frame_done_n, line_err_n;

  logic                vs_rise, acc, last_pix, byte_done;
  logic [7:0]          shifted;
  logic [LW-1:0]       base_line;
  logic [LINE_IDX_WIDTH-1:0] idx;
  logic [15:0]         hdr;

  assign vs_rise   = vsync & ~vsync_d;
  assign acc       = valid & hsync;
  assign last_pix  = (pixel_cnt == PW'(IMAGE_WIDTH - 1));
  assign byte_done = (pixel_cnt[2:0] == 3'd7);
  assign shifted   = {sr, sobel};
  // A frame start on the same edge as the first pixel restarts the index at 0.
  assign base_line = vs_rise ? '0 : line_cnt;
  assign idx       = LINE_IDX_WIDTH'(base_line);
  assign hdr       = 16'(idx);

  always_comb begin
    state_n      = state;
    pixel_cnt_n  = pixel_cnt;
    line_cnt_n   = line_cnt;
    sr_n         = sr;
    hdr_lo_n     = hdr_lo;
    hdr_pend_n   = 1'b0;
    out_data_n   = 8'h00;
    out_valid_n  = 1'b0;
    out_sol_n    = 1'b0;
    out_eol_n    = 1'b0;
    out_abort_n  = 1'b0;
    frame_done_n = 1'b0;
    line_err_n   = line_err;

    if (hdr_pend) begin
      out_valid_n = 1'b1;
      out_data_n  = hdr_lo;
    end

    case (state)
      S_IDLE: begin
        if (vs_rise) begin
          line_cnt_n  = '0;
          pixel_cnt_n = '0;
        end
        if (acc) begin
          state_n     = S_LINE;
          sr_n        = {6'b0, sobel};
          pixel_cnt_n = PW'(1);
          out_valid_n = 1'b1;
          out_sol_n   = 1'b1;
          out_data_n  = hdr[15:8];
          hdr_lo_n    = hdr[7:0];
          hdr_pend_n  = 1'b1;
        end
      end
      S_LINE: begin
        if (acc && last_pix) begin
          // Final pixel wins over a simultaneous frame start: line completes, then index resets.
          out_valid_n = 1'b1;
          out_eol_n   = 1'b1;
          out_data_n  = shifted;
          sr_n        = '0;
          pixel_cnt_n = '0;
          line_cnt_n  = (line_cnt == LW'(IMAGE_HEIGHT)) ? line_cnt : line_cnt + LW'(1);
          if (line_cnt == LW'(IMAGE_HEIGHT - 1)) begin
            frame_done_n = 1'b1;
            state_n      = S_DONE;
          end else begin
            state_n = S_IDLE;
          end
          if (vs_rise) begin
            line_cnt_n = '0;
            state_n    = S_IDLE;
          end
        end else if (vs_rise) begin
          out_valid_n = 1'b0;
          out_data_n  = 8'h00;
          out_abort_n = 1'b1;
          line_err_n  = 1'b1;
          sr_n        = '0;
          pixel_cnt_n = '0;
          line_cnt_n  = '0;
          state_n     = S_IDLE;
        end else if (acc) begin
          pixel_cnt_n = pixel_cnt + PW'(1);
          if (byte_done) begin
            out_valid_n = 1'b1;
            out_data_n  = shifted;
            sr_n        = '0;
          end else begin
            sr_n = shifted[6:0];
          end
        end
      end
      S_DONE: begin
        if (acc) line_err_n = 1'b1;
        if (vs_rise) begin
          state_n     = S_IDLE;
          line_cnt_n  = '0;
          pixel_cnt_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pixel_cnt  <= '0;
      line_cnt   <= '0;
      sr         <= '0;
      vsync_d    <= 1'b0;
      hdr_lo     <= 8'h00;
      hdr_pend   <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_sol    <= 1'b0;
      out_eol    <= 1'b0;
      out_abort  <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      state      <= state_n;
      pixel_cnt  <= pixel_cnt_n;
      line_cnt   <= line_cnt_n;
      sr         <= sr_n;
      vsync_d    <= vsync;
      hdr_lo     <= hdr_lo_n;
      hdr_pend   <= hdr_pend_n;
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      out_sol    <= out_sol_n;
      out_eol    <= out_eol_n;
      out_abort  <= out_abort_n;
      frame_done <= frame_done_n;
      line_err   <= line_err_n;
    end
  end

endmodule

// File: tb/tb_sobel_line_packer.sv
// Scoreboard bench for sobel_line_packer: a per-cycle behavioural frame model queues
// expected packet bytes with their due cycle; a negedge monitor pops and compares.
module tb_sobel_line_packer;
  localparam int W = 16;
  localparam int H = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       valid = 1'b0, hsync = 1'b0, vsync = 1'b0, sobel = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_sol, out_eol, out_abort, frame_done, line_err;

  sobel_line_packer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .LINE_IDX_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .hsync(hsync), .vsync(vsync), .sobel(sobel),
    .out_data(out_data), .out_valid(out_valid), .out_sol(out_sol), .out_eol(out_eol),
    .out_abort(out_abort), .frame_done(frame_done), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    bit         sol;
    bit         eol;
    bit         fd;
    bit         ab;
  } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: 0 = waiting for line, 1 = in line, 2 = frame complete
  int m_mode = 0;
  int m_line = 0;
  bit m_err  = 1'b0;
  bit m_vs_prev = 1'b0;
  bit m_pix[$];

  task automatic push(int c, logic [7:0] d, bit sol, bit eol, bit fd, bit ab);
    ev_t e;
    e.cyc = c; e.d = d; e.sol = sol; e.eol = eol; e.fd = fd; e.ab = ab;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] last_byte();
    logic [7:0] b;
    int n;
    b = 8'h00;
    n = m_pix.size();
    for (int j = 0; j < 8; j++) if (m_pix[n-8+j]) b = b | (8'h80 >> j);
    return b;
  endfunction

  task automatic model(bit v, bit h, bit vs, bit s);
    int t;
    bit vr, acc;
    t  = cyc;
    vr = vs && !m_vs_prev;
    acc = v && h;
    m_vs_prev = vs;
    if (m_mode == 2) begin
      if (acc) m_err = 1'b1;
      if (vr) begin m_mode = 0; m_line = 0; end
    end else if (m_mode == 0) begin
      if (vr) m_line = 0;
      if (acc) begin
        push(t + 1, 8'((m_line >> 8) & 255), 1'b1, 1'b0, 1'b0, 1'b0);
        push(t + 2, 8'(m_line & 255), 1'b0, 1'b0, 1'b0, 1'b0);
        m_pix.delete();
        m_pix.push_back(s);
        m_mode = 1;
      end
    end else begin
      if (acc && m_pix.size() == W - 1) begin
        m_pix.push_back(s);
        push(t + 1, last_byte(), 1'b0, 1'b1, m_line == H - 1, 1'b0);
        m_mode = (m_line == H - 1) ? 2 : 0;
        m_line = (m_line + 1 > H) ? H : m_line + 1;
        m_pix.delete();
        if (vr) begin m_line = 0; m_mode = 0; end
      end else if (vr) begin
        push(t + 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        m_err = 1'b1;
        m_line = 0;
        m_mode = 0;
        m_pix.delete();
      end else if (acc) begin
        m_pix.push_back(s);
        if (m_pix.size() % 8 == 0) push(t + 1, last_byte(), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic step(bit v, bit h, bit vs, bit s);
    valid = v; hsync = h; vsync = vs; sobel = s;
    model(v, h, vs, s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: contiguous, 1: valid every other cycle, 2: random gaps
  task automatic send_line(logic [W-1:0] pat, int mode, int npix, bit vs_last);
    int g;
    for (int k = 0; k < npix; k++) begin
      step(1'b1, 1'b1, vs_last && (k == npix - 1), pat[W-1-k]);
      g = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int i = 0; i < g; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom));
    end
    // valid without hsync must be ignored
    for (int i = 0; i < 2; i++) step(1'($urandom), 1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  ev_t mon_e;
  bit  mon_ok;
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_output: expected data %02h sol%0d eol%0d ab%0d at cyc %0d, still pending at cyc %0d",
                 exp_q[0].d, exp_q[0].sol, exp_q[0].eol, exp_q[0].ab, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (out_valid || out_abort || frame_done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: cyc %0d valid%0d data %02h abort%0d fd%0d, nothing expected",
                   cyc, out_valid, out_data, out_abort, frame_done);
        end else begin
          mon_e = exp_q.pop_front();
          mon_ok = (mon_e.cyc == cyc) && (out_abort == mon_e.ab) && (out_valid == !mon_e.ab) &&
                   (frame_done == mon_e.fd) &&
                   (mon_e.ab || (out_data == mon_e.d && out_sol == mon_e.sol && out_eol == mon_e.eol));
          if (!mon_ok) begin
            n_bad++;
            $display("FAIL packet_byte: got cyc %0d v%0d data %02h sol%0d eol%0d fd%0d ab%0d, expected cyc %0d data %02h sol%0d eol%0d fd%0d ab%0d",
                     cyc, out_valid, out_data, out_sol, out_eol, frame_done, out_abort,
                     mon_e.cyc, mon_e.d, mon_e.sol, mon_e.eol, mon_e.fd, mon_e.ab);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {8'h0, out_data, out_valid, out_sol, out_eol, out_abort, frame_done, line_err, 10'h0}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // basic frame, contiguous pixels
    vsync_pulse();
    idle(2);
    for (int l = 0; l < H; l++) send_line(16'hA0F1, 0, W, 1'b0);
    chk("t1_line_err", 32'(line_err), 32'h0);

    // same frame, valid every other cycle
    vsync_pulse();
    for (int l = 0; l < H; l++) send_line(16'hA0F1, 1, W, 1'b0);
    chk("t2_line_err", 32'(line_err), 32'h0);

    // extra line after the frame completes
    send_line(W'($urandom), 0, W, 1'b0);
    chk("t4_line_err", 32'(line_err), 32'(m_err));
    chk("t4_err_set", 32'(line_err), 32'h1);
    vsync_pulse();
    send_line(16'hA0F1, 0, W, 1'b0);
    for (int l = 1; l < H; l++) send_line(W'($urandom), 2, W, 1'b0);

    // frame start coincident with last pixel of line 1
    vsync_pulse();
    send_line(W'($urandom), 2, W, 1'b0);
    send_line(W'($urandom), 0, W, 1'b1);
    send_line(W'($urandom), 2, W, 1'b0);

    // frame start in the middle of line 2
    vsync_pulse();
    send_line(W'($urandom), 2, W, 1'b0);
    send_line(W'($urandom), 0, W, 1'b0);
    send_line(W'($urandom), 0, 11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_line_err", 32'(line_err), 32'h1);
    for (int l = 0; l < H; l++) send_line(W'($urandom), 2, W, 1'b0);

    // asynchronous reset in the middle of a line
    vsync_pulse();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'($urandom));
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {8'h0, out_data, out_valid, out_sol, out_eol, out_abort, frame_done, line_err, 10'h0}, 32'h0);
    exp_q.delete();
    m_mode = 0; m_line = 0; m_err = 1'b0; m_vs_prev = 1'b0; m_pix.delete();
    valid = 1'b0; hsync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_line(16'hA0F1, 0, W, 1'b0);
    chk("t6_line_err", 32'(line_err), 32'h0);

    // randomized frames
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      idle(int'($urandom_range(0, 3)));
      for (int l = 0; l < H; l++) send_line(W'($urandom), 2, W, 1'b0);
      chk("rand_line_err", 32'(line_err), 32'(m_err));
    end

    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
